deserializer: RTL and testbench

- Downstream partner of the FIR-path serializer: receives its 1-bit stream, LSB first, and reassembles LENGTH-bit sample words.
- Bit framing uses a start-of-word strobe (i_sync) driven alongside bit 0.
- Assembled words are presented on a valid/ready output register for the FIR datapath.
- Overrun and framing errors are flagged for the verification bench and for status logic.

---
 rtl/fir_serial_pkg.sv | 10 +
 rtl/deserializer_if.sv | 24 ++
 rtl/deser_out_reg.sv | 45 ++++
 rtl/deserializer.sv | 99 +++++++++
 tb/tb_deserializer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_serial_pkg.sv
// Shared types and helpers for the FIR serial link (serializer and deserializer).
package fir_serial_pkg;

  typedef enum logic {IDLE, SHIFT} deser_state_t;

  function automatic int cnt_w(input int len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle of the deserializer; slave is the deserializer side.
interface deserializer_if #(parameter int LENGTH = 24);

  logic              i_en;
  logic              i_din;
  logic              i_sync;
  logic              i_ready;
  logic              i_clr_ovr;
  logic [LENGTH-1:0] ov_dout;
  logic              o_valid;
  logic              o_overrun;
  logic              o_frame_err;

  modport master (
    output i_en, i_din, i_sync, i_ready, i_clr_ovr,
    input  ov_dout, o_valid, o_overrun, o_frame_err
  );

  modport slave (
    input  i_en, i_din, i_sync, i_ready, i_clr_ovr,
    output ov_dout, o_valid, o_overrun, o_frame_err
  );

endinterface

// File: rtl/deser_out_reg.sv
// Valid/ready word holding register; a load always lands, overwriting an unaccepted word
// and flagging a sticky overrun (set beats clear). Load to o_valid is one cycle.
module deser_out_reg #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LENGTH-1:0] i_data,
  input  logic              i_ready,
  input  logic              i_clr_ovr,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_valid,
  output logic              o_overrun
);

  logic [LENGTH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              ovr_set;

  always_comb begin
    ovr_set = i_load && valid_q && !i_ready;
    dout_d  = i_load ? i_data : dout_q;
    valid_d = i_load || (valid_q && !i_ready);
    ovr_d   = ovr_set || (ovr_q && !i_clr_ovr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ov_dout   = dout_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;

endmodule

// File: rtl/deserializer.sv
// LSB-first serial to LENGTH-bit word assembler framed by i_sync; word is valid the cycle
// after its last bit is sampled, and a new word overwrites an unaccepted one (overrun).
module deserializer
  import fir_serial_pkg::*;
#(
  parameter int LENGTH = 24
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  deserializer_if.slave  bus
);

  localparam int             CW   = cnt_w(LENGTH);
  localparam logic [CW-1:0]  LAST = CW'(LENGTH - 1);

  deser_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-2:0] shift_q, shift_d;
  logic [LENGTH-2:0] wr_sel;
  logic              frame_err_q, frame_err_d;
  logic              start, advance, last;
  logic [LENGTH-1:0] ld_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_en && bus.i_sync) state_d = SHIFT;
      SHIFT:   if (bus.i_en && !bus.i_sync && cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sync restarts the word from either state; in SHIFT it also truncates the partial word.
  always_comb begin
    start       = bus.i_en && bus.i_sync;
    advance     = (state_q == SHIFT) && bus.i_en && !bus.i_sync;
    last        = advance && (cnt_q == LAST);
    frame_err_d = (state_q == SHIFT) && start;
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < LENGTH - 1; i++) begin
      wr_sel[i] = advance && (cnt_q == CW'(i));
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (start) begin
      shift_d    = '0;
      shift_d[0] = bus.i_din;
      cnt_d      = CW'(1);
    end else if (advance) begin
      for (int i = 0; i < LENGTH - 1; i++) begin
        if (wr_sel[i]) shift_d[i] = bus.i_din;
      end
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The top bit bypasses the shift register so the word is ready at the sampling edge.
  assign ld_data         = {bus.i_din, shift_q};
  assign bus.o_frame_err = frame_err_q;

  deser_out_reg #(.LENGTH(LENGTH)) u_out_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (last),
    .i_data    (ld_data),
    .i_ready   (bus.i_ready),
    .i_clr_ovr (bus.i_clr_ovr),
    .ov_dout   (bus.ov_dout),
    .o_valid   (bus.o_valid),
    .o_overrun (bus.o_overrun)
  );

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed word traffic with a word-level reference model
// compared against the outputs every cycle, plus literal spot checks.
module tb_deserializer;

  localparam int L = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  deserializer_if #(.LENGTH(L)) bus ();

  deserializer #(.LENGTH(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk     = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int ferr_seen = 0;

  // Word-level annotations from the driver: which sampled bit completes a word, and
  // which sync truncates a partial one.
  logic         drv_comp   = 1'b0;
  logic         drv_resync = 1'b0;
  logic [L-1:0] drv_word   = '0;
  bit           partial    = 1'b0;

  logic [L-1:0] m_dout  = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_ferr  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a finished word always lands; the held word is consumed when ready is
  // high; an unconsumed word being replaced raises the sticky overrun.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dout  <= '0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
    end else begin
      m_ferr <= bus.i_en && drv_resync;
      if (bus.i_en && drv_comp) begin
        m_dout  <= drv_word;
        m_valid <= 1'b1;
        if (m_valid && !bus.i_ready) m_ovr <= 1'b1;
        else if (bus.i_clr_ovr)      m_ovr <= 1'b0;
      end else begin
        if (bus.i_ready)   m_valid <= 1'b0;
        if (bus.i_clr_ovr) m_ovr   <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_valid",   64'(bus.o_valid),     64'(m_valid));
    check("cmp_dout",    64'(bus.ov_dout),     64'(m_dout));
    check("cmp_overrun", 64'(bus.o_overrun),   64'(m_ovr));
    check("cmp_ferr",    64'(bus.o_frame_err), 64'(m_ferr));
    if (bus.o_frame_err) ferr_seen++;
  end

  task automatic drive(input logic en, input logic din, input logic sync,
                       input logic comp, input logic resync, input logic [L-1:0] word);
    bus.i_en   = en;
    bus.i_din  = din;
    bus.i_sync = sync;
    drv_comp   = comp;
    drv_resync = resync;
    drv_word   = word;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
  endtask

  // Sends the first nbits of w; ngaps enable-low cycles land at random mid-word spots.
  task automatic send_bits(input logic [L-1:0] w, input int nbits, input int ngaps,
                           input logic rdy_last);
    int gpos[4];
    for (int g = 0; g < 4; g++) gpos[g] = -1;
    for (int g = 0; g < ngaps && g < 4; g++) gpos[g] = $urandom_range(1, nbits - 1);
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < 4; g++) if (gpos[g] == i) idle(1);
      if (i == L - 1) bus.i_ready = rdy_last;
      drive(1'b1, w[i], i == 0, i == L - 1, (i == 0) && partial, w);
    end
    partial = (nbits < L);
  endtask

  task automatic send_word(input logic [L-1:0] w, input int ngaps, input logic rdy_last);
    send_bits(w, L, ngaps, rdy_last);
  endtask

  task automatic wait_valid(input int c0, output int lat);
    int k = 0;
    while (!bus.o_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = cyc - c0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, lat, f0, nb;
    logic [L-1:0] w;
    bus.i_en      = 1'b0;
    bus.i_din     = 1'b0;
    bus.i_sync    = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_clr_ovr = 1'b0;

    #12;
    check("rst_valid",   64'(bus.o_valid),     64'd0);
    check("rst_dout",    64'(bus.ov_dout),     64'd0);
    check("rst_overrun", 64'(bus.o_overrun),   64'd0);
    check("rst_ferr",    64'(bus.o_frame_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, latency and one-cycle valid
    bus.i_ready = 1'b1;
    c0 = cyc;
    send_word(24'hA5C3F0, 0, 1'b1);
    wait_valid(c0, lat);
    check("t1_latency", 64'(lat), 64'd24);
    #3;
    check("t1_valid", 64'(bus.o_valid), 64'd1);
    check("t1_dout",  64'(bus.ov_dout), 64'hA5C3F0);
    idle(1);
    #3;
    check("t1_valid_drop", 64'(bus.o_valid), 64'd0);
    idle(2);

    // Back-to-back words, no dead cycle
    send_word(24'h000001, 0, 1'b1);
    #3;
    check("t2_first", 64'(bus.ov_dout), 64'h000001);
    send_word(24'h800000, 0, 1'b1);
    #3;
    check("t2_second_valid", 64'(bus.o_valid), 64'd1);
    check("t2_second",       64'(bus.ov_dout), 64'h800000);
    idle(2);

    // Three enable gaps stretch latency by three cycles
    c0 = cyc;
    send_word(24'h123456, 3, 1'b1);
    wait_valid(c0, lat);
    check("t3_latency", 64'(lat), 64'd27);
    check("t3_dout",    64'(bus.ov_dout), 64'h123456);
    idle(2);

    // Resync after 10 bits
    f0 = ferr_seen;
    send_bits(24'hFFFFFF, 10, 0, 1'b1);
    send_word(24'h0F0F0F, 0, 1'b1);
    #3;
    check("t4_dout", 64'(bus.ov_dout), 64'h0F0F0F);
    idle(2);
    check("t4_ferr_pulses", 64'(ferr_seen - f0), 64'd1);

    // Backpressure and overrun
    bus.i_ready = 1'b0;
    send_word(24'hAAAAAA, 0, 1'b0);
    send_word(24'h555555, 0, 1'b0);
    #3;
    check("t5_dout",    64'(bus.ov_dout),   64'h555555);
    check("t5_overrun", 64'(bus.o_overrun), 64'd1);
    bus.i_ready = 1'b1;
    idle(1);
    bus.i_ready = 1'b0;
    #3;
    check("t5_valid_after_accept", 64'(bus.o_valid),   64'd0);
    check("t5_overrun_sticky",     64'(bus.o_overrun), 64'd1);
    bus.i_clr_ovr = 1'b1;
    idle(1);
    bus.i_clr_ovr = 1'b0;
    #3;
    check("t5_overrun_clr", 64'(bus.o_overrun), 64'd0);

    // Accept and completion on the same edge: no overrun
    send_word(24'h111111, 0, 1'b0);
    send_word(24'h333333, 0, 1'b1);
    bus.i_ready = 1'b0;
    #3;
    check("t5_simul_dout",    64'(bus.ov_dout),   64'h333333);
    check("t5_simul_overrun", 64'(bus.o_overrun), 64'd0);

    // Overrun set and clear on the same edge: set wins
    bus.i_clr_ovr = 1'b1;
    send_word(24'h222222, 0, 1'b0);
    bus.i_clr_ovr = 1'b0;
    #3;
    check("t5_set_wins", 64'(bus.o_overrun), 64'd1);

    // Asynchronous reset mid-word
    send_bits(24'h0BAD55, 12, 0, 1'b0);
    check("t6_pre_valid", 64'(bus.o_valid), 64'd1);
    check("t6_pre_dout",  64'(bus.ov_dout), 64'h222222);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid",   64'(bus.o_valid),     64'd0);
    check("t6_async_dout",    64'(bus.ov_dout),     64'd0);
    check("t6_async_overrun", 64'(bus.o_overrun),   64'd0);
    check("t6_async_ferr",    64'(bus.o_frame_err), 64'd0);
    partial = 1'b0;
    bus.i_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    send_word(24'hC0FFEE, 0, 1'b1);
    #3;
    check("t6_fresh_dout", 64'(bus.ov_dout), 64'hC0FFEE);
    idle(1);

    // Random traffic against the model
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        nb = $urandom_range(1, L - 1);
        send_bits(L'($urandom), nb, 0, bus.i_ready);
      end
      w = L'($urandom);
      bus.i_ready   = 1'($urandom);
      bus.i_clr_ovr = ($urandom_range(0, 3) == 0);
      send_word(w, $urandom_range(0, 2), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    bus.i_clr_ovr = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
